ex_muldiv_seq: RTL and testbench

Iterative multi-cycle multiply/divide unit for the EX stage. It executes the MUL, MULH, DIV and REM opcodes of the EX-stage op set over XLEN+2 cycles instead of in one combinational pass. It exposes a ready/valid handshake and a busy signal that the pipeline control uses to stall IF/ID/EX while an operation is in flight. One operation is in flight at a time; it supports signed and unsigned variants.

---
 rtl/ex_muldiv_seq_if.sv | 26 ++
 rtl/ex_muldiv_seq.sv | 164 ++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_seq_if.sv
// Request/response bundle between the EX-stage control and the iterative
// multiply/divide unit.
interface ex_muldiv_seq_if #(parameter int XLEN = 64);
  logic            ex_start_in;
  logic [3:0]      ex_alu_op_in;
  logic            ex_signed_in;
  logic [XLEN-1:0] ex_operand1_in;
  logic [XLEN-1:0] ex_operand2_in;
  logic            ex_flush_in;
  logic            ex_ready_out;
  logic            ex_busy_out;
  logic            ex_valid_out;
  logic [XLEN-1:0] ex_result_out;

  modport master (
    output ex_start_in, ex_alu_op_in, ex_signed_in,
           ex_operand1_in, ex_operand2_in, ex_flush_in,
    input  ex_ready_out, ex_busy_out, ex_valid_out, ex_result_out
  );

  modport slave (
    input  ex_start_in, ex_alu_op_in, ex_signed_in,
           ex_operand1_in, ex_operand2_in, ex_flush_in,
    output ex_ready_out, ex_busy_out, ex_valid_out, ex_result_out
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative radix-2 multiply/divide unit for the EX stage: one operand bit per
// cycle on magnitudes, with signs restored in a single FIXUP cycle.
module ex_muldiv_seq #(
  parameter int XLEN = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  ex_muldiv_seq_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   operand_b;
  logic              is_div;
  logic              sel_alt;
  logic              sign1;
  logic              sign2;
  logic              div_zero;
  logic [XLEN-1:0]   result;

  logic              legal_op;
  logic              accept;
  logic              start_div_zero;
  logic [XLEN-1:0]   abs1;
  logic [XLEN-1:0]   abs2;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] product_fixed;
  logic [XLEN-1:0]   quotient_fixed;
  logic [XLEN-1:0]   remainder_fixed;
  logic [XLEN-1:0]   fixup_value;

  assign legal_op = bus.ex_alu_op_in inside {4'b1010, 4'b1011, 4'b1100, 4'b1101};
  assign accept = (state == IDLE) && bus.ex_start_in && legal_op && !bus.ex_flush_in;
  assign start_div_zero = bus.ex_alu_op_in[2] && (bus.ex_operand2_in == '0);

  assign abs1 = (bus.ex_signed_in && bus.ex_operand1_in[XLEN-1]) ? -bus.ex_operand1_in
                                                                 : bus.ex_operand1_in;
  assign abs2 = (bus.ex_signed_in && bus.ex_operand2_in[XLEN-1]) ? -bus.ex_operand2_in
                                                                 : bus.ex_operand2_in;

  // Multiply keeps the multiplier in lo and shifts the partial product into it;
  // divide shifts the dividend out of lo while quotient bits shift in.
  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand_b} : '0);
  assign div_shift = {hi, lo[XLEN-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b0, operand_b};

  assign product         = {hi, lo};
  assign product_fixed   = (sign1 ^ sign2) ? -product : product;
  assign quotient_fixed  = ((sign1 ^ sign2) && !div_zero) ? -lo : lo;
  assign remainder_fixed = (sign1 && !div_zero) ? -hi : hi;

  always_comb begin
    fixup_value = '0;
    case ({is_div, sel_alt})
      2'b00:   fixup_value = product_fixed[XLEN-1:0];
      2'b01:   fixup_value = product_fixed[2*XLEN-1:XLEN];
      2'b10:   fixup_value = quotient_fixed;
      default: fixup_value = remainder_fixed;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = start_div_zero ? FIXUP : CALC;
        end
      end
      CALC: begin
        if (bus.ex_flush_in) begin
          next_state = IDLE;
        end else if (count == '0) begin
          next_state = FIXUP;
        end
      end
      FIXUP: begin
        next_state = bus.ex_flush_in ? IDLE : DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.ex_ready_out  = (state == IDLE);
    bus.ex_busy_out   = (state != IDLE);
    bus.ex_valid_out  = (state == DONE);
    bus.ex_result_out = result;
  end

  // Divide-by-zero preloads the forced quotient/remainder so FIXUP can skip CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      hi        <= '0;
      lo        <= '0;
      operand_b <= '0;
      is_div    <= 1'b0;
      sel_alt   <= 1'b0;
      sign1     <= 1'b0;
      sign2     <= 1'b0;
      div_zero  <= 1'b0;
      result    <= '0;
    end else begin
      if (accept) begin
        count    <= CW'(XLEN - 1);
        is_div   <= bus.ex_alu_op_in[2];
        sel_alt  <= bus.ex_alu_op_in[0];
        sign1    <= bus.ex_signed_in && bus.ex_operand1_in[XLEN-1];
        sign2    <= bus.ex_signed_in && bus.ex_operand2_in[XLEN-1];
        div_zero <= start_div_zero;
        if (start_div_zero) begin
          hi        <= bus.ex_operand1_in;
          lo        <= '1;
          operand_b <= '0;
        end else if (bus.ex_alu_op_in[2]) begin
          hi        <= '0;
          lo        <= abs1;
          operand_b <= abs2;
        end else begin
          hi        <= '0;
          lo        <= abs2;
          operand_b <= abs1;
        end
      end else if (state == CALC) begin
        count <= count - CW'(1);
        if (is_div) begin
          hi <= div_diff[XLEN+1] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
          lo <= {lo[XLEN-2:0], ~div_diff[XLEN+1]};
        end else begin
          hi <= mul_sum[XLEN:1];
          lo <= {mul_sum[0], lo[XLEN-1:1]};
        end
      end
      if ((state == FIXUP) && !bus.ex_flush_in) begin
        result <= fixup_value;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_ex_muldiv_seq;

  localparam int XLEN = 64;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_REM  = 4'b1101;
  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [63:0] prevResult = '0;

  always #5 clk = ~clk;

  ex_muldiv_seq_if #(.XLEN(XLEN)) bus ();

  ex_muldiv_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference results straight from the arithmetic definition of each op.
  function automatic logic [63:0] refModel(input logic [3:0] op, input logic sgn,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea;
    logic [127:0] eb;
    logic [127:0] prod;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    ea = sgn ? {{64{a[63]}}, a} : {64'b0, a};
    eb = sgn ? {{64{b[63]}}, b} : {64'b0, b};
    prod = ea * eb;
    sa = a;
    sb = b;
    case (op)
      OP_MUL:  return prod[63:0];
      OP_MULH: return prod[127:64];
      OP_DIV: begin
        if (b == 64'd0) return '1;
        if (sgn && a == MIN_NEG && b == '1) return MIN_NEG;
        if (sgn) return sa / sb;
        return a / b;
      end
      OP_REM: begin
        if (b == 64'd0) return a;
        if (sgn && a == MIN_NEG && b == '1) return 64'd0;
        if (sgn) return sa % sb;
        return a % b;
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic sgn,
                               input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    bus.ex_start_in    = 1'b1;
    bus.ex_alu_op_in   = op;
    bus.ex_signed_in   = sgn;
    bus.ex_operand1_in = a;
    bus.ex_operand2_in = b;
    @(posedge clk);
    #1;
    bus.ex_start_in    = 1'b0;
    bus.ex_operand1_in = {$urandom, $urandom};
    bus.ex_operand2_in = {$urandom, $urandom};
  endtask

  // Launches one op, optionally pokes a second start while busy, then checks
  // result, latency, busy span, result hold and the single-cycle pulse.
  task automatic runOp(input string tag, input logic [3:0] op, input logic sgn,
                       input logic [63:0] a, input logic [63:0] b, input int injectAt);
    logic [63:0] expected;
    int expLat;
    int lat;
    int busyCnt;
    bit held;
    bit seen;
    expected = refModel(op, sgn, a, b);
    expLat = (op[2] && b == 64'd0) ? 2 : XLEN + 2;
    lat = 0;
    busyCnt = 0;
    held = 1'b1;
    seen = 1'b0;
    applyStimulus(op, sgn, a, b);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (injectAt != 0 && lat == injectAt) begin
        bus.ex_start_in    = 1'b1;
        bus.ex_alu_op_in   = OP_DIV;
        bus.ex_operand1_in = 64'd1000;
        bus.ex_operand2_in = 64'd3;
      end else if (injectAt != 0 && lat == injectAt + 1) begin
        bus.ex_start_in = 1'b0;
      end
      if (bus.ex_busy_out) busyCnt++;
      if (bus.ex_valid_out) seen = 1'b1;
      else if (bus.ex_result_out !== prevResult) held = 1'b0;
    end
    bus.ex_start_in = 1'b0;
    checkOutput({tag, " valid"}, 64'(seen), 64'd1);
    checkOutput({tag, " result"}, bus.ex_result_out, expected);
    checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " busy"}, 64'(busyCnt), 64'(expLat));
    checkOutput({tag, " hold"}, 64'(held), 64'd1);
    @(negedge clk);
    checkOutput({tag, " after"}, 64'({bus.ex_valid_out, bus.ex_busy_out, bus.ex_ready_out}),
                64'd1);
    prevResult = expected;
  endtask

  task automatic watchNoValid(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.ex_valid_out) seen = 1'b1;
    end
    checkOutput({tag, " no valid"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [3:0] ops [4];
    logic [3:0] rop;
    logic rsgn;
    logic [63:0] ra;
    logic [63:0] rb;
    int mode;

    ops[0] = OP_MUL;
    ops[1] = OP_MULH;
    ops[2] = OP_DIV;
    ops[3] = OP_REM;
    bus.ex_start_in    = 1'b0;
    bus.ex_alu_op_in   = 4'b0000;
    bus.ex_signed_in   = 1'b0;
    bus.ex_operand1_in = '0;
    bus.ex_operand2_in = '0;
    bus.ex_flush_in    = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset result", bus.ex_result_out, 64'd0);
    checkOutput("reset flags", 64'({bus.ex_valid_out, bus.ex_busy_out, bus.ex_ready_out}), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed operations");
    runOp("mulu 7x6", OP_MUL, 1'b0, 64'd7, 64'd6, 0);
    runOp("mulh -1x1", OP_MULH, 1'b1, '1, 64'd1, 0);
    runOp("mulhu 2^63x4", OP_MULH, 1'b0, MIN_NEG, 64'd4, 0);
    runOp("div -7/2", OP_DIV, 1'b1, -64'sd7, 64'd2, 0);
    runOp("rem -7/2", OP_REM, 1'b1, -64'sd7, 64'd2, 0);
    runOp("divu max/2", OP_DIV, 1'b0, '1, 64'd2, 0);
    runOp("div ovf", OP_DIV, 1'b1, MIN_NEG, '1, 0);
    runOp("rem ovf", OP_REM, 1'b1, MIN_NEG, '1, 0);
    runOp("div 5/0", OP_DIV, 1'b1, 64'd5, 64'd0, 0);
    runOp("rem 5/0", OP_REM, 1'b1, 64'd5, 64'd0, 0);
    runOp("rem -9/0", OP_REM, 1'b1, -64'sd9, 64'd0, 0);
    runOp("start busy", OP_MUL, 1'b1, -64'sd12345, 64'd6789, 5);

    $display("[TB] illegal op and idle flush");
    applyStimulus(4'b0111, 1'b0, 64'd3, 64'd4);
    @(negedge clk);
    checkOutput("illegal op", 64'({bus.ex_busy_out, bus.ex_ready_out}), 64'd1);
    bus.ex_flush_in = 1'b1;
    applyStimulus(OP_MUL, 1'b0, 64'd3, 64'd4);
    bus.ex_flush_in = 1'b0;
    @(negedge clk);
    checkOutput("idle flush", 64'({bus.ex_busy_out, bus.ex_ready_out}), 64'd1);

    $display("[TB] flush during CALC");
    applyStimulus(OP_MUL, 1'b0, 64'd3, 64'd5);
    repeat (30) @(negedge clk);
    checkOutput("calc busy", 64'(bus.ex_busy_out), 64'd1);
    bus.ex_flush_in = 1'b1;
    @(posedge clk);
    #1;
    bus.ex_flush_in = 1'b0;
    @(negedge clk);
    checkOutput("flush idle", 64'({bus.ex_valid_out, bus.ex_busy_out, bus.ex_ready_out}), 64'd1);
    watchNoValid("flush", 80);
    checkOutput("flush held", bus.ex_result_out, prevResult);

    $display("[TB] reset mid-operation");
    applyStimulus(OP_DIV, 1'b1, 64'd999, 64'd7);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset flags", 64'({bus.ex_valid_out, bus.ex_busy_out, bus.ex_ready_out}),
                64'd1);
    checkOutput("midreset result", bus.ex_result_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prevResult = '0;
    watchNoValid("midreset", 80);
    runOp("post reset", OP_REM, 1'b0, 64'd100, 64'd7, 0);

    $display("[TB] random operations");
    for (int n = 0; n < 16; n++) begin
      rop  = ops[$urandom_range(0, 3)];
      rsgn = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 3);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (mode == 1) begin
        ra = 64'($signed($urandom_range(0, 400)) - 200);
        rb = 64'($signed($urandom_range(1, 40)) - 20);
      end else if (mode == 2) begin
        rb = 64'd0;
      end else if (mode == 3) begin
        ra = ($urandom_range(0, 1) == 1) ? MIN_NEG : '1;
        rb = ($urandom_range(0, 1) == 1) ? '1 : MIN_NEG;
      end
      runOp($sformatf("rand%0d", n), rop, rsgn, ra, rb, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
